auto_corner_detect: RTL and testbench
=====================================

// Module: auto_corner_detect
// PURPOSE
//  Auto-detection engine answering the main FSM's auto_detection_start / auto_detection_done handshake.
//  On a start pulse it scans one stored frame from the frame BRAM and thresholds each pixel.
//  It reports the four extreme bright pixels: TL, TR, BL, BR corners of the document.
//  Corners feed the corner registers ahead of the manual-adjust stage.
// PARAMETERS
//  H_PIXELS    640  frame width in pixels
//  V_PIXELS    480  frame height in pixels
//  X_W         10   x coordinate width
//  Y_W         9    y coordinate width
//  ADDR_W      19   frame BRAM address width; addr = y*H_PIXELS + x
//  PIX_W       8    luma width
//  THRESHOLD   128  pixel counts as "bright" when luma >= THRESHOLD
//  RD_LATENCY  2    BRAM read latency in cycles (1..3)
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high
//  start        in   1       one-cycle pulse, driven by auto_detection_start
//  done         out  1       one-cycle pulse, wired to auto_detection_done
//  busy         out  1       high from the cycle after start is accepted until done
//  rd_addr      out  ADDR_W  frame BRAM read address
//  rd_data      in   PIX_W   luma, valid RD_LATENCY cycles after rd_addr
//  found        out  1       at least one bright pixel in the last scan
//  tl_x,tr_x,bl_x,br_x  out  X_W  corner x; held until the next scan completes
//  tl_y,tr_y,bl_y,br_y  out  Y_W  corner y; held until the next scan completes
// BEHAVIOUR
//  Reset: state IDLE. done=0, busy=0, rd_addr=0, found=0, all corner outputs 0.
//  States:
//   IDLE -start-> SCAN
//   SCAN -last addr issued-> DRAIN
//   DRAIN -RD_LATENCY cycles-> DONE
//   DONE -> IDLE (unconditional)
//  Timing:
//   start sampled high at edge k -> rd_addr=0 in cycle k+1.
//   rd_addr steps raster order, one per cycle; x wraps at H_PIXELS-1, then y increments.
//   done=1 for exactly one cycle, at cycle k+1+H_PIXELS*V_PIXELS+RD_LATENCY.
//  Pixel pipeline: x/y delayed RD_LATENCY stages alongside the read, so rd_data is paired with its coordinates.
//  Metrics, signed, X_W+2 bits, evaluated on bright pixels only:
//   TL = min(x+y); TR = max(x-y); BL = max(y-x); BR = max(x+y).
//   Comparisons are strict, so the first pixel in raster order wins ties.
//  Working trackers: cleared at scan start.
//  Output registers: copied from the trackers only in the DONE cycle, so outputs never show partial results.
//  start while busy or in DONE: ignored; no queueing.
//  start in the same cycle as reset: reset wins.
//  reset mid-scan: return to IDLE; no done pulse; outputs cleared.
//  Single bright pixel: all four corners equal that pixel.
// CONFIGURATION
//  CORNER_FALLBACK_EN defined:
//   scan with no bright pixel loads frame corners (0,0), (H-1,0), (0,V-1), (H-1,V-1); found=0.
//  CORNER_FALLBACK_EN undefined:
//   no-bright scan loads all corners 0; found=0.
//  Either way, done still pulses.
// STRUCTURE
//  Shared header corner_defs.vh holds:
//   - state encodings IDLE/SCAN/DRAIN/DONE (2-bit)
//   - corner index constants TL/TR/BL/BR
//   - metric width macro
//  Sub-module corner_tracker, instantiated 4x. Each one:
//   - holds best metric, x and y plus a valid bit
//   - has inputs clear, en, metric, x, y, and a MODE parameter (MIN/MAX)
// TESTING  (bench uses H_PIXELS=8, V_PIXELS=6, RD_LATENCY=2, BRAM model)
//  1. Bright rectangle x=2..5, y=1..4; pulse start.
//     -> TL(2,1) TR(5,1) BL(2,4) BR(5,4); found=1; done exactly 51 cycles after start.
//  2. Single bright pixel (3,3).
//     -> all four corners (3,3); found=1.
//  3. All-dark frame.
//     -> with CORNER_FALLBACK_EN: TL(0,0) TR(7,0) BL(0,5) BR(7,5); without: all 0; found=0.
//  4. Second start pulse at scan cycle 10.
//     -> ignored; one done pulse; rd_addr sequence 0..47 uninterrupted.
//  5. Reset at scan cycle 20.
//     -> next cycle busy=0, no done, outputs 0; new start gives full correct scan.
//  6. Tied pixels: bright (4,0) and (3,1) only, both x+y=4.
//     -> TL=(4,0), raster-first wins.

Source files
------------

// File: rtl/auto_corner_detect_pkg.sv
// Shared types for the corner-detect engine: FSM states, tracker modes,
// corner indices and the signed metric width.
package auto_corner_detect_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef enum logic {
      MODE_MIN = 1'b0,
      MODE_MAX = 1'b1
   } mode_e;

   localparam int C_TL        = 0;
   localparam int C_TR        = 1;
   localparam int C_BL        = 2;
   localparam int C_BR        = 3;
   localparam int NUM_CORNERS = 4;

   // x+y and x-y need one growth bit plus a sign bit over the x width
   function automatic int metric_w(input int x_w);
      return x_w + 2;
   endfunction

endpackage

// File: rtl/auto_corner_detect_if.sv
// Start/done handshake, frame BRAM read port and corner results.
// master = main FSM / BRAM side, slave = the detection engine.
interface auto_corner_detect_if #(
   parameter int X_W    = 10,
   parameter int Y_W    = 9,
   parameter int ADDR_W = 19,
   parameter int PIX_W  = 8
);
   logic              start;
   logic              done;
   logic              busy;
   logic [ADDR_W-1:0] rd_addr;
   logic [PIX_W-1:0]  rd_data;
   logic              found;
   logic [X_W-1:0]    tl_x, tr_x, bl_x, br_x;
   logic [Y_W-1:0]    tl_y, tr_y, bl_y, br_y;

   modport master (
      output start, rd_data,
      input  done, busy, rd_addr, found,
      input  tl_x, tr_x, bl_x, br_x, tl_y, tr_y, bl_y, br_y
   );

   modport slave (
      input  start, rd_data,
      output done, busy, rd_addr, found,
      output tl_x, tr_x, bl_x, br_x, tl_y, tr_y, bl_y, br_y
   );
endinterface

// File: rtl/auto_corner_detect_tracker.sv
// One corner tracker: keeps the best (min or max) metric seen since clear,
// with its coordinates. Strict compare so the earliest pixel wins ties.
module corner_tracker
   import auto_corner_detect_pkg::*;
#(
   parameter int    MW   = 12,
   parameter int    X_W  = 10,
   parameter int    Y_W  = 9,
   parameter mode_e MODE = MODE_MIN
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 en,
   input  logic signed [MW-1:0] metric,
   input  logic [X_W-1:0]       x,
   input  logic [Y_W-1:0]       y,
   output logic                 valid,
   output logic [X_W-1:0]       best_x,
   output logic [Y_W-1:0]       best_y
);
   logic signed [MW-1:0] best;
   logic                 better;

   always_comb begin
      better = (MODE == MODE_MIN) ? (metric < best) : (metric > best);
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         valid  <= 1'b0;
         best   <= '0;
         best_x <= '0;
         best_y <= '0;
      end else if (en && (!valid || better)) begin
         valid  <= 1'b1;
         best   <= metric;
         best_x <= x;
         best_y <= y;
      end
   end
endmodule

// File: rtl/auto_corner_detect.sv
// Frame-scan corner detector: raster-reads the frame BRAM, thresholds luma and
// reports TL/TR/BL/BR bright extremes. Option: CORNER_FALLBACK_EN (frame corners on empty scan).
module auto_corner_detect
   import auto_corner_detect_pkg::*;
#(
   parameter int H_PIXELS   = 640,
   parameter int V_PIXELS   = 480,
   parameter int X_W        = 10,
   parameter int Y_W        = 9,
   parameter int ADDR_W     = 19,
   parameter int PIX_W      = 8,
   parameter int THRESHOLD  = 128,
   parameter int RD_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   auto_corner_detect_if.slave  bus
);
   localparam int MW = metric_w(X_W);

   state_e            state, state_nxt;
   logic [X_W-1:0]    x_cnt;
   logic [Y_W-1:0]    y_cnt;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        lat_cnt;
   logic              accept, last_addr;

   assign accept    = (state == IDLE) && bus.start;
   assign last_addr = (x_cnt == X_W'(H_PIXELS-1)) && (y_cnt == Y_W'(V_PIXELS-1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = SCAN;
         SCAN:    if (last_addr) state_nxt = DRAIN;
         DRAIN:   if (lat_cnt == 2'(RD_LATENCY-1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_cnt   <= '0;
         y_cnt   <= '0;
         addr    <= '0;
         lat_cnt <= '0;
      end else if (accept) begin
         x_cnt   <= '0;
         y_cnt   <= '0;
         addr    <= '0;
         lat_cnt <= '0;
      end else if (state == SCAN && !last_addr) begin
         addr <= addr + ADDR_W'(1);
         if (x_cnt == X_W'(H_PIXELS-1)) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + Y_W'(1);
         end else begin
            x_cnt <= x_cnt + X_W'(1);
         end
      end else if (state == DRAIN) begin
         lat_cnt <= lat_cnt + 2'd1;
      end
   end

   // vld_pipe[0] mirrors "address issued this cycle"; stage RD_LATENCY lines up with rd_data
   logic [RD_LATENCY:0]          vld_pipe;
   logic [RD_LATENCY:1][X_W-1:0] x_pipe;
   logic [RD_LATENCY:1][Y_W-1:0] y_pipe;

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         x_pipe   <= '0;
         y_pipe   <= '0;
      end else begin
         vld_pipe  <= {vld_pipe[RD_LATENCY-1:0], state_nxt == SCAN};
         x_pipe[1] <= x_cnt;
         y_pipe[1] <= y_cnt;
         for (int i = 2; i <= RD_LATENCY; i++) begin
            x_pipe[i] <= x_pipe[i-1];
            y_pipe[i] <= y_pipe[i-1];
         end
      end
   end

   logic                               bright;
   logic signed [MW-1:0]               sx, sy;
   logic [NUM_CORNERS-1:0][MW-1:0]     metric;
   logic [NUM_CORNERS-1:0]             trk_vld;
   logic [NUM_CORNERS-1:0][X_W-1:0]    trk_x;
   logic [NUM_CORNERS-1:0][Y_W-1:0]    trk_y;

   assign bright = vld_pipe[RD_LATENCY] && (bus.rd_data >= PIX_W'(THRESHOLD));
   assign sx     = signed'(MW'(x_pipe[RD_LATENCY]));
   assign sy     = signed'(MW'(y_pipe[RD_LATENCY]));

   always_comb begin
      metric       = '0;
      metric[C_TL] = sx + sy;
      metric[C_TR] = sx - sy;
      metric[C_BL] = sy - sx;
      metric[C_BR] = sx + sy;
   end

   for (genvar i = 0; i < NUM_CORNERS; i++) begin : g_trk
      corner_tracker #(
         .MW   (MW),
         .X_W  (X_W),
         .Y_W  (Y_W),
         .MODE ((i == C_TL) ? MODE_MIN : MODE_MAX)
      ) u_trk (
         .clk    (clk),
         .reset  (reset),
         .clear  (accept),
         .en     (bright),
         .metric (metric[i]),
         .x      (x_pipe[RD_LATENCY]),
         .y      (y_pipe[RD_LATENCY]),
         .valid  (trk_vld[i]),
         .best_x (trk_x[i]),
         .best_y (trk_y[i])
      );
   end

   // results only move in DONE so a mid-scan read sees the previous frame's corners
   logic                            found_q;
   logic [NUM_CORNERS-1:0][X_W-1:0] cx;
   logic [NUM_CORNERS-1:0][Y_W-1:0] cy;

   always_ff @(posedge clk) begin
      if (reset) begin
         found_q <= 1'b0;
         cx      <= '0;
         cy      <= '0;
      end else if (state == DONE) begin
         found_q <= |trk_vld;
         if (|trk_vld) begin
            cx <= trk_x;
            cy <= trk_y;
         end else begin
`ifdef CORNER_FALLBACK_EN
            cx       <= '0;
            cy       <= '0;
            cx[C_TR] <= X_W'(H_PIXELS-1);
            cx[C_BR] <= X_W'(H_PIXELS-1);
            cy[C_BL] <= Y_W'(V_PIXELS-1);
            cy[C_BR] <= Y_W'(V_PIXELS-1);
`else
            cx <= '0;
            cy <= '0;
`endif
         end
      end
   end

   assign bus.done    = (state == DONE);
   assign bus.busy    = (state == SCAN) || (state == DRAIN);
   assign bus.rd_addr = addr;
   assign bus.found   = found_q;
   assign bus.tl_x    = cx[C_TL];
   assign bus.tr_x    = cx[C_TR];
   assign bus.bl_x    = cx[C_BL];
   assign bus.br_x    = cx[C_BR];
   assign bus.tl_y    = cy[C_TL];
   assign bus.tr_y    = cy[C_TR];
   assign bus.bl_y    = cy[C_BL];
   assign bus.br_y    = cy[C_BR];
endmodule

// File: tb/tb_auto_corner_detect.sv
// Bench for auto_corner_detect on an 8x6 frame with a 2-cycle BRAM model;
// vector table plus scoreboard of expected corner sets.
module tb_auto_corner_detect;
   localparam int H = 8, V = 6, L = 2, NPIX = H * V;
   localparam int X_W = 10, Y_W = 9, ADDR_W = 19, PIX_W = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;

   auto_corner_detect_if #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

   auto_corner_detect #(
      .H_PIXELS(H), .V_PIXELS(V), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W),
      .PIX_W(PIX_W), .THRESHOLD(128), .RD_LATENCY(L)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [64];
   logic [7:0] rd_pipe [L];

   always @(posedge clk) begin
      rd_pipe[0] <= mem[bus.rd_addr[5:0]];
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.rd_data = rd_pipe[L-1];

   typedef struct {
      int ax0, ax1, ay0, ay1;
      int bx0, bx1, by0, by1;
      int bval;
      int found;
      int cx[4];
      int cy[4];
   } vec_t;

   int   n_pass = 0, n_total = 0;
   vec_t vecs[7];
   vec_t sb_q[$];
   vec_t zero_v, last_exp;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic vec_t mk(input int ax0, ax1, ay0, ay1, bx0, bx1, by0, by1,
                               input int bval, found,
                               input int tlx, tly, trx, tr_y, blx, bly, brx, bry);
      vec_t v;
      v.ax0 = ax0; v.ax1 = ax1; v.ay0 = ay0; v.ay1 = ay1;
      v.bx0 = bx0; v.bx1 = bx1; v.by0 = by0; v.by1 = by1;
      v.bval = bval; v.found = found;
      v.cx[0] = tlx; v.cx[1] = trx; v.cx[2] = blx; v.cx[3] = brx;
      v.cy[0] = tly; v.cy[1] = tr_y; v.cy[2] = bly; v.cy[3] = bry;
      return v;
   endfunction

   task automatic load(input vec_t v);
      for (int a = 0; a < 64; a++) begin
         int x, y;
         bit b;
         x = a % H;
         y = a / H;
         b = (x >= v.ax0 && x <= v.ax1 && y >= v.ay0 && y <= v.ay1) ||
             (x >= v.bx0 && x <= v.bx1 && y >= v.by0 && y <= v.by1);
         mem[a] = b ? 8'(v.bval) : 8'($urandom_range(0, 127));
      end
   endtask

   task automatic check_outs(input string tag, input vec_t e);
      int ax[4], ay[4];
      ax = '{int'(bus.tl_x), int'(bus.tr_x), int'(bus.bl_x), int'(bus.br_x)};
      ay = '{int'(bus.tl_y), int'(bus.tr_y), int'(bus.bl_y), int'(bus.br_y)};
      check({tag, ".found"}, int'(bus.found), e.found);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s.c%0d_x", tag, i), ax[i], e.cx[i]);
         check($sformatf("%s.c%0d_y", tag, i), ay[i], e.cy[i]);
      end
   endtask

   // one start pulse, then watch 56 cycles; extra_c/rst_c < 0 disables that injection
   task automatic run(input string tag, input bit push, input vec_t v,
                      input int extra_c, input int rst_c);
      int done_n, done_c;
      bit addr_ok;
      vec_t e;
      done_n = 0; done_c = -1; addr_ok = 1'b1;
      if (push) sb_q.push_back(v);
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      for (int c = 1; c <= 56; c++) begin
         @(negedge clk);
         if (bus.done) begin done_n++; done_c = c; end
         if (c <= NPIX && rst_c < 0 && int'(bus.rd_addr) != c - 1) addr_ok = 1'b0;
         if (c == 1) check({tag, ".busy_c1"}, int'(bus.busy), 1);
         if (c == 25 && rst_c < 0) begin
            check({tag, ".hold_found"}, int'(bus.found), last_exp.found);
            check({tag, ".hold_tl_x"}, int'(bus.tl_x), last_exp.cx[0]);
         end
         if (rst_c >= 0 && c == rst_c + 1) begin
            check({tag, ".rst_busy"}, int'(bus.busy), 0);
            check({tag, ".rst_done"}, int'(bus.done), 0);
            check({tag, ".rst_addr"}, int'(bus.rd_addr), 0);
            check_outs({tag, ".rst"}, zero_v);
         end
         if (done_c > 0 && c == done_c + 1) begin
            check({tag, ".sb_depth"}, sb_q.size(), 1);
            check({tag, ".busy_after"}, int'(bus.busy), 0);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check_outs(tag, e);
               last_exp = e;
            end
         end
         bus.start = (c == extra_c);
         reset     = (c == rst_c);
      end
      bus.start = 1'b0;
      reset     = 1'b0;
      if (rst_c < 0) begin
         check({tag, ".done_count"}, done_n, 1);
         check({tag, ".done_latency"}, done_c, 1 + NPIX + L);
         check({tag, ".addr_seq"}, int'(addr_ok), 1);
      end else begin
         check({tag, ".no_done"}, done_n, 0);
         last_exp = zero_v;
      end
   endtask

   initial begin
      bus.start = 1'b0;
      for (int a = 0; a < 64; a++) mem[a] = 8'd0;
      zero_v = mk(1,0,1,0, 1,0,1,0, 0, 0, 0,0, 0,0, 0,0, 0,0);
      last_exp = zero_v;

      vecs[0] = mk(2,5,1,4, 1,0,1,0, 200, 1, 2,1, 5,1, 2,4, 5,4);
      vecs[1] = mk(3,3,3,3, 1,0,1,0, 128, 1, 3,3, 3,3, 3,3, 3,3);
`ifdef CORNER_FALLBACK_EN
      vecs[2] = mk(1,0,1,0, 1,0,1,0, 255, 0, 0,0, 7,0, 0,5, 7,5);
`else
      vecs[2] = mk(1,0,1,0, 1,0,1,0, 255, 0, 0,0, 0,0, 0,0, 0,0);
`endif
      vecs[3] = mk(4,4,0,0, 3,3,1,1, 255, 1, 4,0, 4,0, 3,1, 4,0);
      vecs[4] = mk(0,7,0,5, 1,0,1,0, 128, 1, 0,0, 7,0, 0,5, 7,5);
      vecs[5] = mk(7,7,5,5, 1,0,1,0, 250, 1, 7,5, 7,5, 7,5, 7,5);
      vecs[6] = mk(1,1,4,4, 6,6,2,2, 180, 1, 1,4, 6,2, 1,4, 6,2);

      // start raised while reset is held must be dropped
      repeat (2) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check("reset.busy", int'(bus.busy), 0);
      check("reset.done", int'(bus.done), 0);
      check("reset.rd_addr", int'(bus.rd_addr), 0);
      check_outs("reset", zero_v);

      for (int i = 0; i < 7; i++) begin
         load(vecs[i]);
         run($sformatf("vec%0d", i), 1'b1, vecs[i], -1, -1);
      end

      load(vecs[0]);
      run("restart_ignored", 1'b1, vecs[0], 10, -1);

      load(vecs[1]);
      run("mid_reset", 1'b0, vecs[1], -1, 20);
      run("after_reset", 1'b1, vecs[1], -1, -1);

      check("sb_empty_end", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
